armleocpu_ptw: RTL
==================

ARMLEOCPU_PTW -- requirements
Module: armleocpu_ptw

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous to clk, active-high.
REQ-003 SHALL have ports: resolve_request in 1, walk request; resolve_virtual_address in 20, VPN[19:0]; satp_ppn in 22, root table PPN.
REQ-004 SHALL have ports: resolve_done out 1, one-cycle result strobe; resolve_pagefault out 1; resolve_accessfault out 1.
REQ-005 SHALL have ports: resolve_physical_address out 22, resolved PPN; resolve_metadata out 8, PTE bits {D,A,G,U,X,W,R,V}, the format the TLB stores and the pagefault checker consumes.
REQ-006 SHALL have memory ports: avl_address out 34; avl_read out 1; avl_waitrequest in 1; avl_readdata in 32; avl_readdatavalid in 1; avl_response in 2, where 2'b00 means OKAY.

Function
REQ-007 SHALL implement the Sv32 two-level walk with states IDLE, ISSUE, WAIT and DONE.
REQ-008 IDLE: when resolve_request=1, SHALL capture the VPN and satp_ppn, set level=1, and go to ISSUE on the next cycle.
REQ-009 ISSUE: SHALL drive avl_read=1 with avl_address={table_ppn, vpn[level], 2'b00} and hold both stable until a cycle with avl_waitrequest=0, then go to WAIT.
REQ-010 WAIT: SHALL keep avl_read=0 and evaluate the PTE in the cycle avl_readdatavalid=1.
REQ-011 When avl_response!=OKAY, SHALL set accessfault and go to DONE.
REQ-012 When PTE.V=0, or PTE.R=0 with PTE.W=1, SHALL set pagefault and go to DONE.
REQ-013 When PTE.R=1 or PTE.X=1 (leaf), SHALL go to DONE with metadata=PTE[7:0] and the physical address taken from the leaf.
REQ-014 For a leaf at level 0, physical address SHALL equal PTE[31:10].
REQ-015 For a leaf at level 1 (megapage), physical address SHALL equal {PTE[31:20], vpn[9:0]}.
REQ-016 For a leaf at level 1 with PTE[19:10]!=0 (misaligned megapage), SHALL set pagefault.
REQ-017 For a pointer PTE (R=X=0, V=1): at level 1, SHALL set table_ppn=PTE[31:10], level=0, and go to ISSUE; at level 0, SHALL set pagefault.
REQ-018 DONE: SHALL assert resolve_done for exactly one cycle, then return to IDLE.
REQ-019 Result outputs SHALL stay stable from DONE until the next accepted request.
REQ-020 A request present during DONE SHALL NOT be accepted; it is accepted in the following IDLE cycle.
REQ-021 Requests SHALL be ignored outside IDLE.
REQ-022 avl_readdatavalid SHALL be ignored outside WAIT.
REQ-023 pagefault and accessfault SHALL be mutually exclusive; accessfault takes priority.
REQ-024 Latency from acceptance (cycle 0) with zero-wait memory: megapage done in cycle 3; 4KiB page done in cycle 5.

Reset
REQ-025 When rst=1, the block SHALL go to IDLE and clear avl_read, resolve_done, resolve_pagefault, resolve_accessfault, resolve_physical_address and resolve_metadata to 0, including mid-walk.
REQ-026 Any read outstanding at reset SHALL be discarded, and no resolve_done SHALL be produced for it.

Configuration
REQ-027 When macro ARMLEOCPU_PTW_MEGAPAGE_EN is defined, a valid level-1 leaf SHALL resolve per REQ-015/REQ-016.
REQ-028 When ARMLEOCPU_PTW_MEGAPAGE_EN is undefined, every level-1 leaf SHALL produce pagefault.

Verification
REQ-029 4KiB walk: satp_ppn=0x00001, VPN=0x00402; memory returns 0x00000801 at 0x1004 and 0x048D14CF at 0x2008 -> exactly two reads at those addresses, done with PPN=0x12345, metadata=0xCF, no faults.
REQ-030 Megapage walk: same request; 0x1004 returns 0x005000CF -> a single read, PPN=0x01402, metadata=0xCF. With ARMLEOCPU_PTW_MEGAPAGE_EN undefined -> pagefault=1.
REQ-031 PTE checks:
- misaligned megapage 0x005004CF at level 1 -> pagefault=1;
- PTE 0x00000000 -> pagefault=1 after one read;
- PTE 0x00000005 -> pagefault=1;
- 0x00000801 at both levels -> pagefault=1 after two reads.
REQ-032 Bus fault: avl_response=2'b10 on the first read -> accessfault=1, pagefault=0, no second read.
REQ-033 Backpressure and reset:
- avl_waitrequest=1 for 3 cycles -> avl_read and avl_address held stable throughout;
- rst=1 during WAIT, then a stray readdatavalid -> no resolve_done, all outputs 0.

Source files
------------

// File: rtl/armleocpu_ptw_if.sv
// Bundle of the PTW resolve port (toward the TLB) and the Avalon-MM read port (toward memory).
// The master modport is the page table walker itself; the slave modport is its environment
// (the requester plus the memory system).
//
// Handshake semantics:
//   resolve: resolve_request is a level sampled only while the walker is idle; the walk
//     result is reported by a single-cycle resolve_done strobe, and the result fields stay
//     valid until the next request is taken.
//   avl: a read is transferred on a rising edge where avl_read=1 and avl_waitrequest=0;
//     address and read are held unchanged while avl_waitrequest=1. The reply arrives later
//     as one cycle of avl_readdatavalid=1 with avl_readdata and avl_response (2'b00 = OKAY).
interface armleocpu_ptw_if;
    logic        resolve_request;
    logic [19:0] resolve_virtual_address;
    logic [21:0] satp_ppn;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [21:0] resolve_physical_address;
    logic [7:0]  resolve_metadata;

    logic [33:0] avl_address;
    logic        avl_read;
    logic        avl_waitrequest;
    logic [31:0] avl_readdata;
    logic        avl_readdatavalid;
    logic [1:0]  avl_response;

    modport master (
        input  resolve_request, resolve_virtual_address, satp_ppn,
        output resolve_done, resolve_pagefault, resolve_accessfault,
        output resolve_physical_address, resolve_metadata,
        output avl_address, avl_read,
        input  avl_waitrequest, avl_readdata, avl_readdatavalid, avl_response
    );

    modport slave (
        output resolve_request, resolve_virtual_address, satp_ppn,
        input  resolve_done, resolve_pagefault, resolve_accessfault,
        input  resolve_physical_address, resolve_metadata,
        input  avl_address, avl_read,
        output avl_waitrequest, avl_readdata, avl_readdatavalid, avl_response
    );
endinterface

// File: rtl/armleocpu_ptw.sv
// Sv32 two-level page table walker.
// Optional feature: define ARMLEOCPU_PTW_MEGAPAGE_EN to allow level-1 (4 MiB megapage) leaves;
// without it every level-1 leaf is reported as a pagefault.
// dbg_state exposes the FSM state: 0=IDLE, 1=ISSUE, 2=WAIT, 3=DONE.
module armleocpu_ptw (
    input  logic                   clk,
    input  logic                   rst,
    armleocpu_ptw_if.master        bus,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic        level, level_nxt;
    logic [19:0] vpn, vpn_nxt;
    logic [21:0] table_ppn, table_ppn_nxt;
    logic        pf, pf_nxt;
    logic        af, af_nxt;
    logic [21:0] pa, pa_nxt;
    logic [7:0]  meta, meta_nxt;

    // PTE permission bits of the word currently on the read data bus
    logic pte_v, pte_r, pte_w, pte_x;
    assign pte_v = bus.avl_readdata[0];
    assign pte_r = bus.avl_readdata[1];
    assign pte_w = bus.avl_readdata[2];
    assign pte_x = bus.avl_readdata[3];

    // State and walk context registers; reset also discards any read in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            level     <= 1'b0;
            vpn       <= '0;
            table_ppn <= '0;
            pf        <= 1'b0;
            af        <= 1'b0;
            pa        <= '0;
            meta      <= '0;
        end else begin
            state     <= state_nxt;
            level     <= level_nxt;
            vpn       <= vpn_nxt;
            table_ppn <= table_ppn_nxt;
            pf        <= pf_nxt;
            af        <= af_nxt;
            pa        <= pa_nxt;
            meta      <= meta_nxt;
        end
    end

    // Next-state logic: request capture, read issue, PTE evaluation
    always_comb begin
        state_nxt     = state;
        level_nxt     = level;
        vpn_nxt       = vpn;
        table_ppn_nxt = table_ppn;
        pf_nxt        = pf;
        af_nxt        = af;
        pa_nxt        = pa;
        meta_nxt      = meta;

        case (state)
            S_IDLE: begin
                if (bus.resolve_request) begin
                    vpn_nxt       = bus.resolve_virtual_address;
                    table_ppn_nxt = bus.satp_ppn;
                    level_nxt     = 1'b1;
                    // Previous result is only dropped once a new walk actually starts
                    pf_nxt        = 1'b0;
                    af_nxt        = 1'b0;
                    pa_nxt        = '0;
                    meta_nxt      = '0;
                    state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!bus.avl_waitrequest) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.avl_readdatavalid) begin
                    state_nxt = S_DONE;
                    if (bus.avl_response != 2'b00) begin
                        // Bus error wins over any PTE interpretation
                        af_nxt = 1'b1;
                    end else if (!pte_v || (!pte_r && pte_w)) begin
                        pf_nxt = 1'b1;
                    end else if (pte_r || pte_x) begin
                        if (level) begin
`ifdef ARMLEOCPU_PTW_MEGAPAGE_EN
                            // Megapage must be 4 MiB aligned: low PPN bits must be zero
                            if (bus.avl_readdata[19:10] != 10'd0) begin
                                pf_nxt = 1'b1;
                            end else begin
                                pa_nxt   = {bus.avl_readdata[31:20], vpn[9:0]};
                                meta_nxt = bus.avl_readdata[7:0];
                            end
`else
                            pf_nxt = 1'b1;
`endif
                        end else begin
                            pa_nxt   = bus.avl_readdata[31:10];
                            meta_nxt = bus.avl_readdata[7:0];
                        end
                    end else if (level) begin
                        // Pointer to the second-level table
                        table_ppn_nxt = bus.avl_readdata[31:10];
                        level_nxt     = 1'b0;
                        state_nxt     = S_ISSUE;
                    end else begin
                        // Pointer at the last level is invalid
                        pf_nxt = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Bus and result outputs decoded from registered state
    always_comb begin
        bus.avl_read                 = (state == S_ISSUE);
        bus.avl_address              = {table_ppn, (level ? vpn[19:10] : vpn[9:0]), 2'b00};
        bus.resolve_done             = (state == S_DONE);
        bus.resolve_pagefault        = pf;
        bus.resolve_accessfault      = af;
        bus.resolve_physical_address = pa;
        bus.resolve_metadata         = meta;
        dbg_state                    = state;
    end

endmodule
